// File: rtl/ifc_chan_arbiter.sv
// Round-robin arbiter and frame sequencer sharing the 16-bit IFC uplink among four channels.
// Emits a header word then FRAME_LEN payload words per granted frame, with stall timeout abort.
module ifc_chan_arbiter #(
    parameter int unsigned FRAME_LEN = 3,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned NCH      = 4,
    localparam int unsigned DW       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*DW-1:0] src_data,
    output logic [NCH-1:0]    src_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [1:0]        out_ch,
    output logic [NCH-1:0]    grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned CW = 8;
    localparam int unsigned SW = 16;

    typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;

    state_t           state, state_d;
    logic [1:0]       last_grant, last_grant_d;
    logic [1:0]       out_ch_d;
    logic [NCH-1:0]   grant_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [SW-1:0]    stall_cnt, stall_cnt_d;
    logic             timeout_d;
    logic             active;
    logic             abort;
    logic             xfer;
    logic [1:0]       cand;
    logic [1:0]       sel;
    logic             sel_ok;

    // Round-robin search starting just after the last served channel
    always_comb begin
        cand   = '0;
        sel    = '0;
        sel_ok = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!sel_ok && req[cand]) begin
                sel    = cand;
                sel_ok = 1'b1;
            end
        end
    end

    assign active = (state == HDR) || (state == DATA);
    // Abort wins over a late handshake in the cycle the stall limit is reached
    assign abort  = active && (stall_cnt == SW'(TIMEOUT));
    assign xfer   = active && out_ready && !abort;

    // Next-state, datapath and stream outputs
    always_comb begin
        state_d      = state;
        grant_d      = grant;
        out_ch_d     = out_ch;
        last_grant_d = last_grant;
        cnt_d        = cnt;
        stall_cnt_d  = stall_cnt;
        timeout_d    = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        src_rd       = '0;
        busy         = (state != IDLE);

        if (active) begin
            if (xfer) begin
                stall_cnt_d = '0;
            end else if (!out_ready) begin
                stall_cnt_d = stall_cnt + SW'(1);
            end
            timeout_d = !out_ready && !abort && (stall_cnt == SW'(TIMEOUT - 1));
        end

        case (state)
            IDLE: begin
                if (sel_ok) begin
                    grant_d     = NCH'(1) << sel;
                    out_ch_d    = sel;
                    stall_cnt_d = '0;
                    state_d     = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = {4'hA, 2'b00, out_ch, CW'(FRAME_LEN)};
                if (abort) begin
                    stall_cnt_d = '0;
                    state_d     = GAP;
                end else if (xfer) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                out_valid = 1'b1;
                out_data  = src_data[{out_ch, 4'b0000} +: DW];
                out_last  = (cnt == CW'(FRAME_LEN - 1));
                if (abort) begin
                    stall_cnt_d = '0;
                    state_d     = GAP;
                end else if (xfer) begin
                    src_rd[out_ch] = 1'b1;
                    cnt_d          = cnt + CW'(1);
                    if (out_last) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                last_grant_d = out_ch;
                grant_d      = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; last_grant resets to 3 so ch0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= '0;
            out_ch      <= '0;
            last_grant  <= 2'd3;
            cnt         <= '0;
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            grant       <= grant_d;
            out_ch      <= out_ch_d;
            last_grant  <= last_grant_d;
            cnt         <= cnt_d;
            stall_cnt   <= stall_cnt_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ifc_chan_arbiter.sv
// Directed bench for ifc_chan_arbiter: three instances cover FRAME_LEN=3, TIMEOUT=4 and FRAME_LEN=1.
module tb_ifc_chan_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] src_data;
    logic        out_ready;

    logic [3:0]  a_src_rd, b_src_rd, c_src_rd;
    logic        a_valid, b_valid, c_valid;
    logic [15:0] a_data, b_data, c_data;
    logic        a_last, b_last, c_last;
    logic [1:0]  a_ch, b_ch, c_ch;
    logic [3:0]  a_grant, b_grant, c_grant;
    logic        a_busy, b_busy, c_busy;
    logic        a_te, b_te, c_te;

    int checks = 0;
    int errors = 0;
    int tsel   = 0;

    logic [7:0] ptr [4];
    logic [3:0] rd_sel;

    ifc_chan_arbiter #(.FRAME_LEN(3), .TIMEOUT(255)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data), .src_rd(a_src_rd),
        .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_last(a_last),
        .out_ch(a_ch), .grant(a_grant), .busy(a_busy), .timeout_err(a_te));

    ifc_chan_arbiter #(.FRAME_LEN(3), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data), .src_rd(b_src_rd),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_last(b_last),
        .out_ch(b_ch), .grant(b_grant), .busy(b_busy), .timeout_err(b_te));

    ifc_chan_arbiter #(.FRAME_LEN(1), .TIMEOUT(255)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data), .src_rd(c_src_rd),
        .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data), .out_last(c_last),
        .out_ch(c_ch), .grant(c_grant), .busy(c_busy), .timeout_err(c_te));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source words: ch2 carries the plan's values, others {ch, 5, index}
    function automatic logic [15:0] word(input int ch, input logic [7:0] i);
        if (ch == 2 && i == 8'd0) return 16'h2003;
        if (ch == 2 && i == 8'd1) return 16'h1122;
        if (ch == 2 && i == 8'd2) return 16'h3344;
        return {4'(ch), 4'h5, i};
    endfunction

    always_comb begin
        case (tsel)
            0:       rd_sel = a_src_rd;
            1:       rd_sel = b_src_rd;
            default: rd_sel = c_src_rd;
        endcase
    end

    // Per-channel FIFO model: advances on each pop from the instance under test
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) ptr[k] <= 8'd0;
        end else begin
            for (int k = 0; k < 4; k++) if (rd_sel[k]) ptr[k] <= ptr[k] + 8'd1;
        end
    end

    always_comb src_data = {word(3, ptr[3]), word(2, ptr[2]), word(1, ptr[1]), word(0, ptr[0])};

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b0;
        #1;
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", a_valid); end
        checks++; if (a_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", a_data); end
        checks++; if (a_src_rd !== 4'b0000) begin errors++; $display("FAIL rst_src_rd got %b exp 0000", a_src_rd); end
        checks++; if (a_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", a_grant); end
        checks++; if ({a_busy, a_last, a_te, a_ch} !== 5'b0) begin errors++; $display("FAIL rst_misc got %b exp 00000", {a_busy, a_last, a_te, a_ch}); end
        do_reset();
    endtask

    task automatic test_single;
        logic        e_valid [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] e_data  [7] = '{16'h0000, 16'hA203, 16'h2003, 16'h1122, 16'h3344, 16'h0000, 16'h0000};
        logic        e_last  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  e_rd    [7] = '{4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
        logic [3:0]  e_grant [7] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
        logic        e_busy  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tsel = 0;
        do_reset();
        tick();
        req       = 4'b0100;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            if (k == 1) req = 4'b0000;
            #1;
            checks++; if (a_valid !== e_valid[k]) begin errors++; $display("FAIL single_valid[%0d] got %b exp %b", k, a_valid, e_valid[k]); end
            checks++; if (a_data !== e_data[k]) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", k, a_data, e_data[k]); end
            checks++; if (a_last !== e_last[k]) begin errors++; $display("FAIL single_last[%0d] got %b exp %b", k, a_last, e_last[k]); end
            checks++; if (a_src_rd !== e_rd[k]) begin errors++; $display("FAIL single_src_rd[%0d] got %b exp %b", k, a_src_rd, e_rd[k]); end
            checks++; if (a_grant !== e_grant[k]) begin errors++; $display("FAIL single_grant[%0d] got %b exp %b", k, a_grant, e_grant[k]); end
            checks++; if (a_busy !== e_busy[k]) begin errors++; $display("FAIL single_busy[%0d] got %b exp %b", k, a_busy, e_busy[k]); end
        end
        checks++; if (a_ch !== 2'd2) begin errors++; $display("FAIL single_ch got %0d exp 2", a_ch); end
    endtask

    task automatic test_round_robin;
        logic [15:0] e_hdr [5] = '{16'hA003, 16'hA103, 16'hA203, 16'hA303, 16'hA003};
        logic [3:0]  e_g   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        tsel = 0;
        do_reset();
        tick();
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            tick();
            #1;
            if ((cyc - 1) % 6 == 0) begin
                checks++; if (a_data !== e_hdr[(cyc - 1) / 6]) begin errors++; $display("FAIL rr_hdr[%0d] got %h exp %h", cyc, a_data, e_hdr[(cyc - 1) / 6]); end
                checks++; if (a_grant !== e_g[(cyc - 1) / 6]) begin errors++; $display("FAIL rr_grant[%0d] got %b exp %b", cyc, a_grant, e_g[(cyc - 1) / 6]); end
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure;
        tsel = 0;
        do_reset();
        tick();
        req       = 4'b0100;
        out_ready = 1'b1;
        tick();
        req = 4'b0000;
        #1;
        checks++; if (a_data !== 16'hA203) begin errors++; $display("FAIL bp_hdr got %h exp A203", a_data); end
        tick();
        #1;
        checks++; if (a_data !== 16'h2003) begin errors++; $display("FAIL bp_w0 got %h exp 2003", a_data); end
        for (int k = 0; k < 5; k++) begin
            tick();
            out_ready = 1'b0;
            #1;
            checks++; if (a_data !== 16'h1122) begin errors++; $display("FAIL bp_hold[%0d] got %h exp 1122", k, a_data); end
            checks++; if ({a_valid, a_src_rd, a_te} !== 6'b1_0000_0) begin errors++; $display("FAIL bp_stall[%0d] got %b exp 100000", k, {a_valid, a_src_rd, a_te}); end
        end
        tick();
        out_ready = 1'b1;
        #1;
        checks++; if ({a_data, a_src_rd} !== {16'h1122, 4'b0100}) begin errors++; $display("FAIL bp_resume got %h/%b exp 1122/0100", a_data, a_src_rd); end
        tick();
        #1;
        checks++; if ({a_data, a_last, a_src_rd} !== {16'h3344, 1'b1, 4'b0100}) begin errors++; $display("FAIL bp_last got %h/%b/%b exp 3344/1/0100", a_data, a_last, a_src_rd); end
        tick();
        #1;
        checks++; if ({a_valid, a_te} !== 2'b00) begin errors++; $display("FAIL bp_gap got %b exp 00", {a_valid, a_te}); end
    endtask

    task automatic test_timeout;
        tsel = 1;
        do_reset();
        tick();
        req       = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL to_idle got %b exp 0", b_busy); end
        tick();
        #1;
        checks++; if (b_data !== 16'hA003) begin errors++; $display("FAIL to_hdr got %h exp A003", b_data); end
        tick();
        #1;
        checks++; if ({b_data, b_src_rd} !== {16'h0500, 4'b0001}) begin errors++; $display("FAIL to_w0 got %h/%b exp 0500/0001", b_data, b_src_rd); end
        for (int k = 3; k <= 8; k++) begin
            tick();
            out_ready = 1'b0;
            #1;
            checks++; if (b_te !== (k == 7)) begin errors++; $display("FAIL to_err[%0d] got %b exp %b", k, b_te, (k == 7)); end
            checks++; if (b_valid !== (k <= 7)) begin errors++; $display("FAIL to_valid[%0d] got %b exp %b", k, b_valid, (k <= 7)); end
            checks++; if (b_src_rd !== 4'b0000) begin errors++; $display("FAIL to_src_rd[%0d] got %b exp 0000", k, b_src_rd); end
        end
        tick();
        out_ready = 1'b1;
        #1;
        checks++; if ({b_busy, b_te, b_grant} !== 6'b0) begin errors++; $display("FAIL to_back_idle got %b exp 000000", {b_busy, b_te, b_grant}); end
        tick();
        #1;
        checks++; if ({b_data, b_grant} !== {16'hA103, 4'b0010}) begin errors++; $display("FAIL to_next got %h/%b exp A103/0010", b_data, b_grant); end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_frame;
        tsel = 0;
        do_reset();
        tick();
        req       = 4'b0100;
        out_ready = 1'b1;
        tick();
        req = 4'b0000;
        tick();
        tick();
        #1;
        checks++; if (a_data !== 16'h1122) begin errors++; $display("FAIL mid_pre got %h exp 1122", a_data); end
        rst_n = 1'b0;
        req   = 4'b0010;
        #1;
        checks++; if ({a_valid, a_data, a_last, a_ch, a_grant, a_busy, a_te, a_src_rd} !== 30'b0) begin
            errors++; $display("FAIL mid_async got %h exp 0", {a_valid, a_data, a_last, a_ch, a_grant, a_busy, a_te, a_src_rd});
        end
        @(posedge clk);
        #2;
        checks++; if ({a_valid, a_src_rd} !== 5'b0) begin errors++; $display("FAIL mid_held got %b exp 00000", {a_valid, a_src_rd}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        checks++; if ({a_data, a_grant, a_ch} !== {16'hA103, 4'b0010, 2'd1}) begin errors++; $display("FAIL mid_after got %h/%b/%0d exp A103/0010/1", a_data, a_grant, a_ch); end
        req = 4'b0000;
    endtask

    task automatic test_frame_len1;
        tsel = 2;
        do_reset();
        tick();
        req       = 4'b0001;
        out_ready = 1'b1;
        #1;
        checks++; if ({c_busy, c_valid} !== 2'b00) begin errors++; $display("FAIL f1_idle got %b exp 00", {c_busy, c_valid}); end
        tick();
        req = 4'b0000;
        #1;
        checks++; if (c_data !== 16'hA001) begin errors++; $display("FAIL f1_hdr got %h exp A001", c_data); end
        tick();
        #1;
        checks++; if ({c_data, c_last, c_src_rd} !== {16'h0500, 1'b1, 4'b0001}) begin errors++; $display("FAIL f1_word got %h/%b/%b exp 0500/1/0001", c_data, c_last, c_src_rd); end
        tick();
        #1;
        checks++; if ({c_valid, c_busy, c_src_rd} !== 6'b0_1_0000) begin errors++; $display("FAIL f1_gap got %b exp 010000", {c_valid, c_busy, c_src_rd}); end
        tick();
        #1;
        checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL f1_done got %b exp 0", c_busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_frame();
        test_frame_len1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
